fp_mul_writeback: RTL and testbench
===================================

FP_MUL_WRITEBACK -- requirements
Module: fp_mul_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, result-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter FTZ, default 1, flush denormal results to signed zero on writeback.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 prod_valid  input  1  multiplier result available.
REQ-006 prod  input  32  IEEE-754 single product from the FP multiplier.
REQ-007 prod_rd  input  5  destination FP register of the product.
REQ-008 prod_ready  output  1  buffer can accept a result.
REQ-009 wb_req  output  1  request for the shared FP register-file write port.
REQ-010 wb_grant  input  1  write port granted this cycle.
REQ-011 wb_addr  output  5  write address.
REQ-012 wb_data  output  32  write data.
REQ-013 flush  input  1  discard all buffered results.
REQ-014 raw_addr  input  5  source register queried by decode.
REQ-015 raw_hit  output  1  raw_addr matches a buffered, unwritten result.
REQ-016 flags_clr  input  1  clear sticky exception flags.
REQ-017 flags  output  3  sticky {invalid, overflow, underflow}.
REQ-018 busy  output  1  buffer non-empty.

Function
REQ-019 SHALL store results in a DEPTH-entry circular FIFO (wr_ptr, rd_ptr, count 0..DEPTH); push = prod_valid && prod_ready; pop = wb_req && wb_grant.
REQ-020 prod_ready SHALL equal (count != DEPTH), registered-state only; no push when full, even if a pop occurs the same cycle.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 wb_req, wb_addr, wb_data SHALL be driven from the head entry only; wb_req = (count != 0); no combinational path prod -> wb_*.
REQ-023 Latency: a result accepted on edge N SHALL present wb_req=1 in the cycle after edge N when the FIFO was empty.
REQ-024 wb_addr/wb_data SHALL hold stable while wb_req=1 and wb_grant=0.
REQ-025 On push, classify prod: exp==255 && man!=0 -> invalid; exp==255 && man==0 -> overflow; exp==0 && man!=0 -> underflow.
REQ-026 With FTZ=1, an underflow-class result SHALL be stored as {sign, 31'b0}; FTZ=0 stores it unchanged.
REQ-027 flags SHALL be sticky OR of classifications of pushed results; flags_clr clears them; a same-cycle push classification SHALL survive the clear.
REQ-028 flush SHALL zero count and both pointers next edge, ignore any same-cycle push and pop, and preserve flags.
REQ-029 raw_hit SHALL be 1 when any valid entry's rd equals raw_addr (combinational on raw_addr and stored state); register 0 is not special.
REQ-030 busy SHALL equal (count != 0).

Reset
REQ-031 rst SHALL have priority over flush and all handshakes; next edge: count=0, pointers=0, flags=0, entries' data undefined but never visible.
REQ-032 After reset: prod_ready=1, wb_req=0, raw_hit=0, busy=0, flags=0; reset mid-transfer drops buffered results without a write.

Structure
REQ-033 FP field constants (EXP_MAX=8'hFF, field bit ranges) SHALL live in shared package fp_pkg, reused by the multiplier.
REQ-034 Classification/FTZ logic SHALL be one sub-module fp_classify (combinational, 32-bit in, 3 flags + adjusted value out); FIFO inline.

Verification
REQ-035 Push 0x40C00000 rd=3, wb_grant=1 -> next cycle wb_req=1, wb_addr=3, wb_data=0x40C00000; then busy=0.
REQ-036 wb_grant=0, push 0x3F800000 then 0x40000000 -> prod_ready=0 after second push; third prod_valid ignored; grants drain in order.
REQ-037 Push 0x7FC00000, then 0x7F800000, then 0x00000001 (FTZ=1) -> flags=3'b111, third wb_data=0x00000000; flags_clr -> 3'b000.
REQ-038 Buffer rd=7 ungranted, raw_addr=7 -> raw_hit=1; raw_addr=8 -> 0; after grant -> 0.
REQ-039 Full FIFO, assert flush with prod_valid=1 -> next cycle count=0, wb_req=0, flags unchanged.
REQ-040 rst asserted with two buffered entries and wb_grant=1 -> no further wb_req; all outputs at REQ-032 values.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout and constants,
// used by the FP multiplier and its writeback buffer.
package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
    localparam int MAN_W    = MAN_MSB + 1;

    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;

    // Bit order of the sticky flag vector: {invalid, overflow, underflow}
    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

endpackage

// File: rtl/fp_classify.sv
// Classifies a single-precision product and optionally flushes
// denormals to a signed zero before it is buffered.
module fp_classify
    import fp_pkg::*;
#(
    parameter bit FTZ = 1'b1
) (
    input  logic [31:0] val_i,
    output logic        invalid_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic [31:0] val_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             man_nz;

    assign exp_f  = val_i[EXP_MSB:EXP_LSB];
    assign man_f  = val_i[MAN_MSB:0];
    assign man_nz = (man_f != '0);

    assign invalid_o   = (exp_f == EXP_MAX) && man_nz;
    assign overflow_o  = (exp_f == EXP_MAX) && !man_nz;
    assign underflow_o = (exp_f == EXP_ZERO) && man_nz;

    always_comb begin
        val_o = val_i;
        if (FTZ && underflow_o) begin
            val_o = {val_i[SIGN_BIT], 31'b0};
        end
    end

endmodule

// File: rtl/fp_mul_writeback.sv
// Result buffer between the FP multiplier and the shared FP
// register-file write port, with RAW lookup and sticky flags.
module fp_mul_writeback
    import fp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter bit FTZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prod_valid,
    input  logic [31:0] prod,
    input  logic [4:0]  prod_rd,
    output logic        prod_ready,
    output logic        wb_req,
    input  logic        wb_grant,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic        flush,
    input  logic [4:0]  raw_addr,
    output logic        raw_hit,
    input  logic        flags_clr,
    output logic [2:0]  flags,
    output logic        busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    flags_q, flags_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [4:0]    rd_q   [DEPTH];
    logic [4:0]    rd_d   [DEPTH];

    logic          cls_inv, cls_ovf, cls_unf;
    logic [31:0]   prod_adj;
    logic [2:0]    cls;
    logic          push, pop;
    logic [PW-1:0] off;

    fp_classify #(.FTZ(FTZ)) u_classify (
        .val_i       (prod),
        .invalid_o   (cls_inv),
        .overflow_o  (cls_ovf),
        .underflow_o (cls_unf),
        .val_o       (prod_adj)
    );

    always_comb begin
        cls           = '0;
        cls[FLAG_INV] = cls_inv;
        cls[FLAG_OVF] = cls_ovf;
        cls[FLAG_UNF] = cls_unf;
    end

    assign prod_ready = (count_q != CW'(DEPTH));
    assign wb_req     = (count_q != '0);
    assign busy       = wb_req;
    assign wb_addr    = rd_q[rd_ptr_q];
    assign wb_data    = data_q[rd_ptr_q];
    assign flags      = flags_q;

    // Flush discards same-cycle handshakes, so gate them here once.
    assign push = prod_valid && prod_ready && !flush;
    assign pop  = wb_req && wb_grant && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        flags_d  = flags_q;
        data_d   = data_q;
        rd_d     = rd_q;
        if (flags_clr) begin
            flags_d = '0;
        end
        if (push) begin
            data_d[wr_ptr_q] = prod_adj;
            rd_d[wr_ptr_q]   = prod_rd;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            flags_d          = flags_d | cls;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end

    // Entry payload needs no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        rd_q   <= rd_d;
    end

    always_comb begin
        raw_hit = 1'b0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (rd_q[i] == raw_addr)) begin
                raw_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_writeback.sv
// Scoreboard bench for fp_mul_writeback: directed scenarios
// followed by randomized traffic against a queue-based model.
module tb_fp_mul_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        prod_valid;
    logic [31:0] prod;
    logic [4:0]  prod_rd;
    logic        prod_ready;
    logic        wb_req;
    logic        wb_grant;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic [4:0]  raw_addr;
    logic        raw_hit;
    logic        flags_clr;
    logic [2:0]  flags;
    logic        busy;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];
    logic [2:0]  m_flags;
    int          n_vec = 0;
    int          n_err = 0;

    fp_mul_writeback #(.DEPTH(DEPTH), .FTZ(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_rd    (prod_rd),
        .prod_ready (prod_ready),
        .wb_req     (wb_req),
        .wb_grant   (wb_grant),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .raw_addr   (raw_addr),
        .raw_hit    (raw_hit),
        .flags_clr  (flags_clr),
        .flags      (flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_class(input logic [31:0] p);
        int e;
        int m;
        e = int'((p >> 23) & 32'hFF);
        m = int'(p & 32'h007F_FFFF);
        return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m != 0};
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] p);
        logic [2:0] c;
        c = ref_class(p);
        return c[0] ? (p & 32'h8000_0000) : p;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, want, $time);
        end
    endtask

    // Monitor: retire the head of the expected queue on each write.
    always @(negedge clk) begin
        if (!rst && !flush && wb_req && wb_grant) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'(wb_req), 32'd0);
            end else begin
                check("wb_addr", 32'(wb_addr), 32'(exp_q[0].rd));
                check("wb_data", wb_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input bit v, input logic [31:0] p,
                        input logic [4:0] rd, input bit g,
                        input bit fl, input bit clr,
                        input logic [4:0] ra);
        bit hit;
        bit pushed;
        prod_valid = v;
        prod       = p;
        prod_rd    = rd;
        wb_grant   = g;
        flush      = fl;
        flags_clr  = clr;
        raw_addr   = ra;
        rst        = 1'b0;
        #1;
        hit = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].rd == ra) hit = 1'b1;
        check("prod_ready", 32'(prod_ready), 32'(exp_q.size() < DEPTH));
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
        check("wb_req", 32'(wb_req), 32'(exp_q.size() != 0));
        check("flags", 32'(flags), 32'(m_flags));
        check("raw_hit", 32'(raw_hit), 32'(hit));
        if (exp_q.size() != 0) begin
            check("head_addr", 32'(wb_addr), 32'(exp_q[0].rd));
            check("head_data", wb_data, exp_q[0].data);
        end
        pushed = v && (exp_q.size() < DEPTH) && !fl;
        if (clr) m_flags = 3'b000;
        if (pushed) begin
            m_flags = m_flags | ref_class(p);
            exp_q.push_back('{rd: rd, data: ref_data(p)});
        end
        if (fl) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit g);
        rst        = 1'b1;
        prod_valid = 1'b1;
        prod       = 32'h7FC0_0000;
        prod_rd    = 5'd1;
        wb_grant   = g;
        flush      = 1'b1;
        flags_clr  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_flags = 3'b000;
    endtask

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom_range(1, 32'h7F_FFFF));
        case ($urandom_range(0, 5))
            0: return $urandom();
            1: return {s, 8'hFF, m};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 8'h00, m};
            4: return {s, 31'd0};
            default: return {s, 8'($urandom_range(1, 254)), m};
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        prod_valid = 1'b0;
        prod = '0;
        prod_rd = '0;
        wb_grant = 1'b0;
        flush = 1'b0;
        flags_clr = 1'b0;
        raw_addr = '0;
        m_flags = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Single result, granted immediately.
        step(1, 32'h40C0_0000, 3, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 3);
        step(0, 0, 0, 1, 0, 0, 3);

        // Fill while ungranted, then drain in order.
        step(1, 32'h3F80_0000, 1, 0, 0, 0, 0);
        step(1, 32'h4000_0000, 2, 0, 0, 0, 0);
        step(1, 32'h4040_0000, 9, 0, 0, 0, 9);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);

        // Exception classes and FTZ; clear afterwards.
        step(1, 32'h7FC0_0000, 4, 1, 0, 0, 0);
        step(1, 32'h7F80_0000, 5, 1, 0, 0, 0);
        step(1, 32'h0000_0001, 6, 1, 0, 0, 0);
        step(1, 32'h8000_0003, 6, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // Clear with a same-cycle overflow push keeps the new flag.
        step(1, 32'hFF80_0000, 2, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);

        // RAW lookup on a held entry.
        step(1, 32'h4100_0000, 7, 0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 8);
        step(0, 0, 0, 1, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 7);

        // Flush of a full buffer with a NaN push pending.
        step(1, 32'h0000_0010, 10, 0, 0, 0, 0);
        step(1, 32'h3F00_0000, 11, 0, 0, 0, 0);
        step(1, 32'h7FC0_0001, 12, 1, 1, 0, 10);
        step(0, 0, 0, 0, 0, 0, 10);

        // Reset with two buffered entries and grant asserted.
        step(1, 32'h3F80_0000, 13, 0, 0, 0, 0);
        step(1, 32'h7F80_0000, 14, 0, 0, 0, 0);
        do_reset(1'b1);
        step(0, 0, 0, 1, 0, 0, 13);
        step(0, 0, 0, 1, 0, 0, 14);

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 9) < 7, rand_fp(),
                 5'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0,
                 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
        end

        // Drain and confirm every expected write was seen.
        repeat (DEPTH + 1) step(0, 0, 0, 1, 0, 0, 0);
        check("drain_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
